// File: rtl/control_unit.sv
// Instruction-sequencing FSM: fetch, decode and execute micro-states
// that issue the 23-bit datapath control word each cycle.
module control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  ir_in,
  input  logic        ac_zero,
  output logic [22:0] control,
  output logic        halted
);

  typedef enum logic [4:0] {
    S_FETCH1, S_FETCH2, S_DECODE,
    S_LD1, S_LD2, S_LD3, S_LD4,
    S_ST1, S_ST2, S_ST3,
    S_MVR, S_MVA,
    S_ADD, S_SUB, S_INC,
    S_JMP, S_SKIP, S_HALT
  } state_t;

  localparam logic [3:0] BUS_IR_NONE = 4'd0;
  localparam logic [3:0] BUS_DR      = 4'd4;
  localparam logic [3:0] BUS_R       = 4'd5;
  localparam logic [3:0] BUS_AC      = 4'd6;
  localparam logic [3:0] BUS_DRAM    = 4'd7;
  localparam logic [3:0] BUS_IRAM    = 4'd8;

  localparam logic [1:0] ADDR_PC = 2'b00;
  localparam logic [1:0] ADDR_AR = 2'b01;

  localparam int unsigned R_LD  = 14;
  localparam int unsigned AR_LD = 15;
  localparam int unsigned DR_LD = 16;
  localparam int unsigned AC_LD = 17;
  localparam int unsigned PC_LD = 18;
  localparam int unsigned IR_LD = 19;

  state_t      state;
  state_t      state_nx;
  logic [22:0] cw;

  always_ff @(posedge clock) begin
    if (reset) state <= S_FETCH1;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = S_FETCH1;
    cw       = '0;
    cw[5:2]  = BUS_IR_NONE;
    unique case (state)
      S_FETCH1: begin
        cw[21:20] = ADDR_PC;
        cw[5:2]   = BUS_IRAM;
        cw[IR_LD] = 1'b1;
        state_nx  = S_FETCH2;
      end
      S_FETCH2: begin
        cw[8]    = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        case (ir_in)
          8'h01:   state_nx = S_LD1;
          8'h02:   state_nx = S_ST1;
          8'h03:   state_nx = S_MVR;
          8'h04:   state_nx = S_MVA;
          8'h05:   state_nx = S_ADD;
          8'h06:   state_nx = S_SUB;
          8'h07:   state_nx = S_INC;
          8'h08:   state_nx = S_JMP;
          8'h09:   state_nx = ac_zero ? S_JMP : S_SKIP;
          8'hff:   state_nx = S_HALT;
          default: state_nx = S_FETCH1;
        endcase
      end
      S_LD1, S_ST1: begin
        cw[21:20] = ADDR_PC;
        cw[5:2]   = BUS_IRAM;
        cw[AR_LD] = 1'b1;
        state_nx  = (state == S_LD1) ? S_LD2 : S_ST2;
      end
      S_LD2, S_ST2: begin
        cw[8]    = 1'b1;
        state_nx = (state == S_LD2) ? S_LD3 : S_ST3;
      end
      S_LD3: begin
        cw[21:20] = ADDR_AR;
        cw[5:2]   = BUS_DRAM;
        cw[DR_LD] = 1'b1;
        state_nx  = S_LD4;
      end
      S_LD4: begin
        cw[5:2]   = BUS_DR;
        cw[AC_LD] = 1'b1;
      end
      S_ST3: begin
        cw[21:20] = ADDR_AR;
        cw[5:2]   = BUS_AC;
        cw[0]     = 1'b1;
      end
      S_MVR: begin
        cw[5:2]  = BUS_AC;
        cw[R_LD] = 1'b1;
      end
      S_MVA: begin
        cw[5:2]   = BUS_R;
        cw[AC_LD] = 1'b1;
      end
      S_ADD, S_SUB, S_INC: begin
        cw[5:2]   = BUS_R;
        cw[AC_LD] = 1'b1;
        cw[22]    = 1'b1;
        cw[10:9]  = (state == S_ADD) ? 2'b00 :
                    (state == S_SUB) ? 2'b01 : 2'b10;
      end
      S_JMP: begin
        cw[21:20] = ADDR_PC;
        cw[5:2]   = BUS_IRAM;
        cw[PC_LD] = 1'b1;
      end
      S_SKIP: cw[8] = 1'b1;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_FETCH1;
    endcase
  end

  // Gating on reset keeps the word quiet during the reset cycle itself,
  // so an aborted store never reaches DRAM.
  assign control = reset ? '0 : cw;
  assign halted  = !reset && (state == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit against an
// instruction-level model of the control word sequence.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ir_in = 8'h00;
  logic        ac_zero = 1'b0;
  logic [22:0] control;
  logic        halted;

  control_unit dut (
    .clock   (clock),
    .reset   (reset),
    .ir_in   (ir_in),
    .ac_zero (ac_zero),
    .control (control),
    .halted  (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [22:0] c;
    logic        h;
    string       tag;
  } exp_t;

  exp_t        q[$];
  logic [22:0] seq[$];
  int          errors = 0;
  int          checks = 0;
  bit          done = 0;

  localparam int B_AC = 6, B_R = 5, B_DR = 4;
  localparam int B_DRAM = 7, B_IRAM = 8;
  localparam int R_LD = 14, AR_LD = 15, DR_LD = 16;
  localparam int AC_LD = 17, PC_LD = 18, IR_LD = 19;

  function automatic logic [22:0] cw(int bus, int addr, int ld,
                                     bit inc, int alu, bit src,
                                     bit wr);
    logic [22:0] w;
    w = '0;
    w[5:2] = bus[3:0];
    w[21:20] = addr[1:0];
    if (ld >= 0) w[ld] = 1'b1;
    w[8] = inc;
    w[10:9] = alu[1:0];
    w[22] = src;
    w[0] = wr;
    return w;
  endfunction

  // Expected words for one whole instruction, fetch included.
  function automatic void build(logic [7:0] op, bit az);
    seq.delete();
    seq.push_back(cw(B_IRAM, 0, IR_LD, 0, 0, 0, 0));
    seq.push_back(cw(0, 0, -1, 1, 0, 0, 0));
    seq.push_back(23'h0);
    case (op)
      8'h01: begin
        seq.push_back(cw(B_IRAM, 0, AR_LD, 0, 0, 0, 0));
        seq.push_back(cw(0, 0, -1, 1, 0, 0, 0));
        seq.push_back(cw(B_DRAM, 1, DR_LD, 0, 0, 0, 0));
        seq.push_back(cw(B_DR, 0, AC_LD, 0, 0, 0, 0));
      end
      8'h02: begin
        seq.push_back(cw(B_IRAM, 0, AR_LD, 0, 0, 0, 0));
        seq.push_back(cw(0, 0, -1, 1, 0, 0, 0));
        seq.push_back(cw(B_AC, 1, -1, 0, 0, 0, 1));
      end
      8'h03: seq.push_back(cw(B_AC, 0, R_LD, 0, 0, 0, 0));
      8'h04: seq.push_back(cw(B_R, 0, AC_LD, 0, 0, 0, 0));
      8'h05: seq.push_back(cw(B_R, 0, AC_LD, 0, 0, 1, 0));
      8'h06: seq.push_back(cw(B_R, 0, AC_LD, 0, 1, 1, 0));
      8'h07: seq.push_back(cw(B_R, 0, AC_LD, 0, 2, 1, 0));
      8'h08: seq.push_back(cw(B_IRAM, 0, PC_LD, 0, 0, 0, 0));
      8'h09:
        if (az) seq.push_back(cw(B_IRAM, 0, PC_LD, 0, 0, 0, 0));
        else    seq.push_back(cw(0, 0, -1, 1, 0, 0, 0));
      default: ;
    endcase
  endfunction

  task automatic step(logic [7:0] ir, logic az, logic rst,
                      logic [22:0] c, logic h, string tag);
    exp_t e;
    @(posedge clock);
    #1;
    ir_in = ir;
    ac_zero = az;
    reset = rst;
    e.c = c;
    e.h = h;
    e.tag = tag;
    q.push_back(e);
  endtask

  // ir_in and ac_zero are scrambled outside DECODE on purpose.
  task automatic run_instr(logic [7:0] op, bit az, int abort_k);
    string tag;
    tag = $sformatf("op%02h", op);
    build(op, az);
    for (int k = 0; k < seq.size(); k++) begin
      if (k == abort_k) begin
        step(8'($urandom), 1'($urandom), 1'b1, '0, 1'b0,
             {tag, "_rst"});
        return;
      end
      if (k == 2) step(op, az, 1'b0, seq[k], 1'b0, tag);
      else step(8'($urandom), 1'($urandom), 1'b0, seq[k], 1'b0,
                tag);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (control !== e.c) begin
          errors++;
          $display("FAIL %s control got %06h want %06h at %0t",
                   e.tag, control, e.c, $time);
        end
        checks++;
        if (halted !== e.h) begin
          errors++;
          $display("FAIL %s halted got %0b want %0b at %0t",
                   e.tag, halted, e.h, $time);
        end
      end
    end
  end

  initial begin : driver
    logic [7:0] op;
    int         r;
    int         ab;
    step(8'h00, 1'b0, 1'b1, '0, 1'b0, "reset");
    step(8'h00, 1'b0, 1'b1, '0, 1'b0, "reset");
    repeat (3) run_instr(8'h00, 0, -1);
    for (int i = 1; i <= 8; i++) run_instr(8'(i), 0, -1);
    run_instr(8'h09, 1, -1);
    run_instr(8'h09, 0, -1);
    run_instr(8'h3a, 0, -1);
    run_instr(8'h01, 0, 5);
    run_instr(8'h02, 1, -1);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 9) op = 8'(r);
      else op = 8'($urandom_range(10, 254));
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(op, 1'($urandom), ab);
    end
    run_instr(8'hff, 0, -1);
    repeat (100)
      step(8'($urandom), 1'($urandom), 1'b0, '0, 1'b1, "halt");
    step(8'h00, 1'b0, 1'b1, '0, 1'b0, "halt_rst");
    run_instr(8'h01, 0, -1);
    run_instr(8'h07, 0, -1);
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
